uart_cmd_scheduler: RTL
=======================

UART_CMD_SCHEDULER -- requirements
Module: uart_cmd_scheduler

Interface
REQ-001 Parameters SHALL be:
- FIFO_DEPTH, 4, number of buffered command frames (power of 2, 2..16).
- TIMEOUT_CYCLES, 255, cycles to wait for reg_ack before aborting.
REQ-002 Ports SHALL be:
- clk, in, 1, clock.
- reset_n, in, 1, asynchronous active-low reset.
- frame_valid, in, 1, one-cycle pulse when a 24-bit frame is complete.
- frame_data, in, 24, frame: [23:16] opcode, [15:8] address, [7:0] data.
- reg_req, out, 1, register-port request, held until reg_ack.
- reg_we, out, 1, 1 = write, 0 = read; valid while reg_req.
- reg_addr, out, 8, register address; valid while reg_req.
- reg_wdata, out, 8, write data; valid while reg_req.
- reg_ack, in, 1, one-cycle completion pulse from the register port.
- reg_rdata, in, 8, read data; valid with reg_ack.
- tx_start, out, 1, one-cycle pulse that launches one UART byte.
- tx_byte, out, 8, byte to send; stable from tx_start until tx_done.
- tx_done, in, 1, one-cycle pulse when the UART byte has been sent.
- overflow, out, 1, sticky: a frame was dropped because the FIFO was full.
- busy, out, 1, high while the FSM is not in IDLE or the FIFO is non-empty.

Function
REQ-003 Each frame_valid SHALL write frame_data into the FIFO in the same cycle, provided the FIFO is not full.
REQ-004 A frame_valid arriving while the FIFO is full SHALL be discarded and SHALL set overflow; FIFO contents SHALL be unchanged.
REQ-005 A simultaneous push and pop SHALL be legal at any occupancy, including full; when full, the pop frees the slot first, so no overflow occurs.
REQ-006 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-007 The FSM states SHALL be IDLE, FETCH, EXEC, TX_STAT, WAIT_STAT, TX_DATA, WAIT_DATA.
REQ-008 State transitions SHALL be:
- IDLE -> FETCH when the FIFO is non-empty.
- FETCH: pop the head frame into holding registers, then go to EXEC.
- EXEC -> TX_STAT.
REQ-009 In EXEC, opcode handling SHALL be:
- 0x01 (write): assert reg_req with reg_we=1.
- 0x02 (read): assert reg_req with reg_we=0.
- Any other opcode: go directly to TX_STAT with status 0xE1, with no reg_req.
REQ-010 reg_req SHALL rise one cycle after FETCH, remain high until the cycle reg_ack is sampled, and deassert the following cycle. On reg_ack: status 0xA0; response data = reg_rdata for a read, or the echoed write data for a write.
REQ-011 TX_STAT SHALL pulse tx_start with tx_byte = status, then go to WAIT_STAT. WAIT_STAT -> TX_DATA on tx_done.
REQ-012 TX_DATA SHALL pulse tx_start with tx_byte = response data (0x00 for error statuses), then go to WAIT_DATA. WAIT_DATA -> IDLE on tx_done.
REQ-013 Minimum latency SHALL be 3 cycles from frame_valid into an empty FIFO to reg_req high.
REQ-014 Frames SHALL be executed strictly in arrival order, one at a time, with no overlap of register access and transmission.
REQ-015 reg_ack or tx_done pulses arriving in any other state SHALL be ignored.

Reset
REQ-016 Asserting reset_n low SHALL immediately set: FSM to IDLE, FIFO empty, reg_req=0, reg_we=0, reg_addr=0, reg_wdata=0, tx_start=0, tx_byte=0, overflow=0, busy=0, timeout counter=0.
REQ-017 A reset during a transaction SHALL abandon it; no tx_start or reg_req SHALL be issued for the abandoned frame after reset is released.

Configuration
REQ-018 With CMD_TIMEOUT_EN defined, a counter SHALL run while reg_req is high; if it reaches TIMEOUT_CYCLES without reg_ack, reg_req SHALL drop and the FSM SHALL go to TX_STAT with status 0xE2 and data 0x00.
REQ-019 Without CMD_TIMEOUT_EN, no counter SHALL be implemented, and the FSM SHALL wait for reg_ack indefinitely.

Verification
REQ-020 Write frame 0x01_10_5A, reg_ack 2 cycles later -> reg_we=1, reg_addr=0x10, reg_wdata=0x5A; then tx bytes 0xA0, 0x5A.
REQ-021 Read frame 0x02_22_00 with reg_rdata=0xC3 -> reg_we=0; then tx bytes 0xA0, 0xC3.
REQ-022 Frame 0x7F_00_00 -> no reg_req; tx bytes 0xE1, 0x00.
REQ-023 Six back-to-back frames while tx_done is stalled -> first five processed in order (one in flight plus four buffered), the sixth dropped, overflow=1.
REQ-024 With CMD_TIMEOUT_EN, read with reg_ack never asserted -> reg_req drops after 255 cycles; tx bytes 0xE2, 0x00.
REQ-025 reset_n pulsed low during WAIT_STAT -> all outputs 0, FIFO empty, no further tx_start.

Source files
------------

// File: rtl/uart_cmd_scheduler.sv
// uart_cmd_scheduler: buffers 24-bit command frames, runs them on the register port, returns status+data bytes over UART.
// Optional CMD_TIMEOUT_EN: abort a register access with status 0xE2 after TIMEOUT_CYCLES without reg_ack.
module uart_cmd_scheduler #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_valid,
    input  logic [23:0] frame_data,
    output logic        reg_req,
    output logic        reg_we,
    output logic [7:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    input  logic        reg_ack,
    input  logic [7:0]  reg_rdata,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    input  logic        tx_done,
    output logic        overflow,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, TX_STAT, WAIT_STAT, TX_DATA, WAIT_DATA} state_t;
    state_t state, state_nx;

    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    op, addr, wdata, status, resp;
    logic          full, push, pop, is_cmd, is_rd, tmo;

    assign full   = count == (AW+1)'(FIFO_DEPTH);
    assign pop    = state == FETCH;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted then.
    assign push   = frame_valid && (!full || pop);
    assign is_cmd = op == 8'h01 || op == 8'h02;
    assign is_rd  = op == 8'h02;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= frame_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            overflow <= overflow | (frame_valid & ~push);
        end
    end

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tmo_cnt <= '0;
        else tmo_cnt <= (reg_req && !reg_ack && !tmo) ? tmo_cnt + 1'b1 : '0;
    end
    assign tmo = reg_req && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            op     <= '0;
            addr   <= '0;
            wdata  <= '0;
            status <= '0;
            resp   <= '0;
        end else begin
            state <= state_nx;
            if (pop) {op, addr, wdata} <= mem[rd_ptr];
            if (state == EXEC && state_nx == TX_STAT) begin
                status <= !is_cmd ? 8'hE1 : reg_ack ? 8'hA0 : 8'hE2;
                resp   <= (is_cmd && reg_ack) ? (is_rd ? reg_rdata : wdata) : 8'h00;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        reg_req   = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = 8'h00;
        reg_wdata = 8'h00;
        tx_start  = 1'b0;
        tx_byte   = 8'h00;
        busy      = state != IDLE || count != '0;
        case (state)
            IDLE:      if (count != '0) state_nx = FETCH;
            FETCH:     state_nx = EXEC;
            EXEC: begin
                reg_req   = is_cmd;
                reg_we    = is_cmd && !is_rd;
                reg_addr  = is_cmd ? addr : 8'h00;
                reg_wdata = is_cmd ? wdata : 8'h00;
                if (!is_cmd || reg_ack || tmo) state_nx = TX_STAT;
            end
            TX_STAT: begin
                tx_start = 1'b1;
                tx_byte  = status;
                state_nx = WAIT_STAT;
            end
            WAIT_STAT: begin
                tx_byte = status;
                if (tx_done) state_nx = TX_DATA;
            end
            TX_DATA: begin
                tx_start = 1'b1;
                tx_byte  = resp;
                state_nx = WAIT_DATA;
            end
            WAIT_DATA: begin
                tx_byte = resp;
                if (tx_done) state_nx = IDLE;
            end
            default:   state_nx = IDLE;
        endcase
    end
endmodule
